// File: rtl/iiitb_pusr.sv
// Parametrised universal shift register with a multi-cycle shift sequencer.
// One command per start: load, hold, shift, rotate or arithmetic shift right.
module iiitb_pusr #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] data_in,
   input  logic             sl_ser,
   input  logic             sr_ser,
   output logic [WIDTH-1:0] data_out,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [AMT_W-1:0] cnt;
   logic [AMT_W-1:0] cnt_n;
   logic [2:0]       op;
   logic [2:0]       op_n;
   logic [WIDTH-1:0] data_n;
   logic             ser_n;
   logic [WIDTH-1:0] step_d;
   logic             step_s;
   logic             is_shift;

   // Load (010) and the two hold codes (x11) never enter SHIFT.
   assign is_shift = (mode[1:0] != 2'b11) && (mode != 3'b010);

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

   always_comb begin
      step_d = data_out;
      step_s = ser_out;
      case (op)
         3'b000: begin
            step_d = {data_out[WIDTH-2:0], sl_ser};
            step_s = data_out[WIDTH-1];
         end
         3'b001: begin
            step_d = {sr_ser, data_out[WIDTH-1:1]};
            step_s = data_out[0];
         end
         3'b100: begin
            step_d = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
            step_s = data_out[WIDTH-1];
         end
         3'b101: begin
            step_d = {data_out[0], data_out[WIDTH-1:1]};
            step_s = data_out[0];
         end
         3'b110: begin
            step_d = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
            step_s = data_out[0];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      op_n    = op;
      data_n  = data_out;
      ser_n   = ser_out;
      unique case (state)
         IDLE, DONE: begin
            state_n = IDLE;
            if (start) begin
               state_n = DONE;
               if (mode == 3'b010) begin
                  data_n = data_in;
               end else if (is_shift && amount != '0) begin
                  op_n    = mode;
                  cnt_n   = amount;
                  state_n = SHIFT;
               end
            end
         end
         SHIFT: begin
            data_n = step_d;
            ser_n  = step_s;
            cnt_n  = cnt - AMT_W'(1);
            if (cnt == AMT_W'(1))
               state_n = DONE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state    <= IDLE;
         cnt      <= '0;
         op       <= '0;
         data_out <= '0;
         ser_out  <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         op       <= op_n;
         data_out <= data_n;
         ser_out  <= ser_n;
      end
   end

endmodule

// File: tb/tb_iiitb_pusr.sv
// Bench for iiitb_pusr: directed spec cases plus random commands
// checked against a behavioural register model.
module tb_iiitb_pusr;

   logic       clock = 1'b0;
   logic       clear;
   logic       start;
   logic [2:0] mode;
   logic [3:0] amount;
   logic [7:0] data_in;
   logic       sl_ser;
   logic       sr_ser;
   logic [7:0] data_out;
   logic       ser_out;
   logic       busy;
   logic       done;

   int compared = 0;
   int mismatched = 0;

   logic [7:0] m_data;
   logic       m_ser;

   iiitb_pusr #(.WIDTH(8), .AMT_W(4)) dut (
      .clock   (clock),
      .clear   (clear),
      .start   (start),
      .mode    (mode),
      .amount  (amount),
      .data_in (data_in),
      .sl_ser  (sl_ser),
      .sr_ser  (sr_ser),
      .data_out(data_out),
      .ser_out (ser_out),
      .busy    (busy),
      .done    (done)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic b, input logic d);
      check({tag, " data"}, 32'(data_out), 32'(m_data));
      check({tag, " ser"}, 32'(ser_out), 32'(m_ser));
      check({tag, " busy"}, 32'(busy), 32'(b));
      check({tag, " done"}, 32'(done), 32'(d));
   endtask

   // Arithmetic description of one step of each shifting command.
   task automatic model_step(input logic [2:0] m, input logic si);
      case (m)
         3'd0: begin
            m_ser  = m_data[7];
            m_data = (m_data << 1) | 8'(si);
         end
         3'd1: begin
            m_ser  = m_data[0];
            m_data = (m_data >> 1) | (8'(si) << 7);
         end
         3'd4: begin
            m_ser  = m_data[7];
            m_data = (m_data << 1) | (m_data >> 7);
         end
         3'd5: begin
            m_ser  = m_data[0];
            m_data = (m_data >> 1) | (m_data << 7);
         end
         3'd6: begin
            m_ser  = m_data[0];
            m_data = 8'($signed(m_data) >>> 1);
         end
         default: ;
      endcase
   endtask

   // Called just after a rising edge; returns just after a rising edge.
   task automatic cmd(input logic [2:0] m, input int amt,
                      input logic [7:0] din, input logic use_seq,
                      input logic [7:0] seq, input logic b2b);
      logic shifting;
      start   = 1'b1;
      mode    = m;
      amount  = 4'(amt);
      data_in = din;
      @(posedge clock); #1;
      start   = 1'b0;
      mode    = 3'($urandom);
      amount  = 4'($urandom);
      data_in = 8'($urandom);
      shifting = (m != 3'd2) && (m[1:0] != 2'b11) && (amt != 0);
      if (m == 3'd2)
         m_data = din;
      if (!shifting) begin
         check_all("accept simple", 1'b0, 1'b1);
      end else begin
         check_all("accept shift", 1'b1, 1'b0);
         for (int k = 1; k <= amt; k++) begin
            sl_ser = 1'($urandom);
            sr_ser = 1'($urandom);
            if (use_seq) begin
               sl_ser = seq[(8 - k) & 7];
               sr_ser = seq[(8 - k) & 7];
            end
            start = 1'($urandom);
            mode  = 3'($urandom);
            @(posedge clock); #1;
            model_step(m, (m == 3'd0) ? sl_ser : sr_ser);
            start = 1'b0;
            check_all($sformatf("step%0d", k), k < amt, k == amt);
         end
      end
      if (!b2b) begin
         @(posedge clock); #1;
         check_all("idle after", 1'b0, 1'b0);
      end
   endtask

   initial begin
      clear   = 1'b0;
      start   = 1'b0;
      mode    = 3'd0;
      amount  = 4'd0;
      data_in = 8'd0;
      sl_ser  = 1'b0;
      sr_ser  = 1'b0;
      m_data  = 8'd0;
      m_ser   = 1'b0;
      #12;
      check_all("reset", 1'b0, 1'b0);
      @(negedge clock) clear = 1'b1;
      @(posedge clock); #1;

      // Asynchronous clear after a load, mid-cycle.
      cmd(3'd2, 0, 8'hFF, 1'b0, 8'h00, 1'b0);
      check("load FF", 32'(data_out), 32'hFF);
      #2 clear = 1'b0;
      #1;
      m_data = 8'd0;
      m_ser  = 1'b0;
      check_all("async clear", 1'b0, 1'b0);
      @(negedge clock) clear = 1'b1;
      @(posedge clock); #1;

      // Clear during SHIFT aborts with no done.
      cmd(3'd2, 0, 8'hAA, 1'b0, 8'h00, 1'b0);
      start  = 1'b1;
      mode   = 3'd0;
      amount = 4'd6;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (2) @(posedge clock);
      #3 clear = 1'b0;
      #1;
      m_data = 8'd0;
      m_ser  = 1'b0;
      check_all("clear in shift", 1'b0, 1'b0);
      @(negedge clock) clear = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         check("no done after abort", 32'(done), 32'(0));
      end

      // Directed cases from the test plan.
      cmd(3'd2, 0, 8'hAB, 1'b0, 8'h00, 1'b0);
      check("load AB", 32'(data_out), 32'hAB);
      cmd(3'd1, 3, 8'h00, 1'b1, 8'hFF, 1'b0);
      check("shr3 data", 32'(data_out), 32'hF5);
      check("shr3 ser", 32'(ser_out), 32'(0));
      cmd(3'd2, 0, 8'hAB, 1'b0, 8'h00, 1'b0);
      cmd(3'd4, 8, 8'h00, 1'b0, 8'h00, 1'b0);
      check("rol8", 32'(data_out), 32'hAB);
      cmd(3'd4, 1, 8'h00, 1'b0, 8'h00, 1'b0);
      check("rol1 data", 32'(data_out), 32'h57);
      check("rol1 ser", 32'(ser_out), 32'(1));
      cmd(3'd2, 0, 8'h90, 1'b0, 8'h00, 1'b0);
      cmd(3'd6, 2, 8'h00, 1'b0, 8'h00, 1'b0);
      check("asr2", 32'(data_out), 32'hE4);
      cmd(3'd0, 0, 8'h11, 1'b0, 8'h00, 1'b0);
      check("amt0 unchanged", 32'(data_out), 32'hE4);
      cmd(3'd3, 5, 8'h22, 1'b0, 8'h00, 1'b0);
      cmd(3'd7, 5, 8'h33, 1'b0, 8'h00, 1'b0);
      check("hold unchanged", 32'(data_out), 32'hE4);
      cmd(3'd2, 0, 8'h3C, 1'b0, 8'h00, 1'b1);
      cmd(3'd5, 3, 8'h00, 1'b0, 8'h00, 1'b0);
      check("b2b ror3", 32'(data_out), 32'h87);
      cmd(3'd0, 8, 8'h00, 1'b1, 8'hB2, 1'b0);
      check("stream", 32'(data_out), 32'hB2);

      // Random commands, some issued back to back during DONE.
      for (int i = 0; i < 60; i++)
         cmd(3'($urandom), $urandom_range(0, 15), 8'($urandom),
             1'b0, 8'h00, 1'($urandom));
      @(posedge clock); #1;
      check_all("final", 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/iiitb_pusr.md
# iiitb_pusr

Parametrised universal shift register with a multi-cycle shift sequencer. It replaces the fixed 8-bit universal shift register in the lab datapath. It accepts one command per handshake: parallel load, hold, logical shift, rotate or arithmetic shift right, each shift repeated by a programmable amount, one position per clock. It reports progress through `busy`, a one-cycle `done` pulse and a serial output of the last bit shifted out.

## Interface
- `WIDTH`, 8: register width in bits; legal range is 2 or more.
- `AMT_W`, 4: width of `amount`; maximum shift count is 2^AMT_W-1.

- `clock` in 1: single clock; all state updates on its rising edge.
- `clear` in 1: asynchronous, active-low reset.
- `start` in 1: command request; sampled on a rising edge.
- `mode` in 3: command code.
  - 000 shift left; 001 shift right; 010 parallel load; 011 hold.
  - 100 rotate left; 101 rotate right; 110 arithmetic shift right; 111 hold (reserved).
- `amount` in AMT_W: number of one-position steps; ignored for load and hold.
- `data_in` in WIDTH: parallel load value.
- `sl_ser` in 1: serial input entering the LSB on shift left.
- `sr_ser` in 1: serial input entering the MSB on shift right.
- `data_out` out WIDTH: register contents.
- `ser_out` out 1: bit expelled by the most recent shift or rotate step.
- `busy` out 1: high while shift steps are in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- States are IDLE, SHIFT and DONE.
- A command is accepted when `start`=1 on a rising edge while the state is IDLE or DONE. `start` in SHIFT is ignored; there is no queue.
- Action on acceptance:
  - Mode 010: `data_out`<=`data_in`, next state DONE.
  - Mode 011/111, or `amount`=0 with any shift mode: register unchanged, next state DONE.
  - Otherwise: latch mode, set the internal counter to `amount`, next state SHIFT. No register change on the accept edge.
- SHIFT performs one step per edge and decrements the counter. When the step with counter=1 executes, the next state is DONE.
- Step definitions (MSB = bit WIDTH-1):
  - Shift left: {d[W-2:0], sl_ser}; ser_out<=d[W-1].
  - Shift right: {sr_ser, d[W-1:1]}; ser_out<=d[0].
  - Rotate left: {d[W-2:0], d[W-1]}; ser_out<=d[W-1].
  - Rotate right: {d[0], d[W-1:1]}; ser_out<=d[0].
  - Arithmetic shift right: {d[W-1], d[W-1:1]}; ser_out<=d[0].
- `sl_ser`/`sr_ser` are sampled live at every step edge, not latched at accept, so streaming input is supported.
- `amount` may exceed WIDTH; steps simply continue. Rotate by WIDTH restores the original value.
- DONE lasts exactly one cycle, then moves to IDLE unless a new command is accepted on that edge.
- `ser_out` holds its value except on step edges. Load and hold do not change it.
- `mode`, `amount` and `data_in` changes during SHIFT have no effect.

## Timing
- Reset: `clear`=0 immediately forces `data_out`=0, `ser_out`=0, `busy`=0, `done`=0, state IDLE and counter 0, regardless of clock.
- Release of `clear` is synchronous-safe; the first accept is possible on the first rising edge with `clear`=1.
- Reset mid-SHIFT aborts the command; no `done` is produced.
- Shift command with amount N≥1, accepted at edge E0:
  - `busy`=1 from after E0 through edge E0+N.
  - Steps occur at E0+1 … E0+N; the final `data_out` is valid after E0+N.
  - `done`=1 during the cycle E0+N … E0+N+1.
- Load, hold or amount=0 accepted at E0: `busy` never asserts; `done`=1 for the cycle after E0. For load, `data_out` is updated at E0.
- `busy` and `done` are never high together.
- Back-to-back commands: a start accepted during DONE begins the next command with no idle cycle.

## Test plan
- Async reset: load 8'hFF, drop `clear` mid-cycle → `data_out`=0, `ser_out`=0, `busy`=0, `done`=0 before the next edge. Repeat during SHIFT → no `done` after release.
- Load: mode 010, `data_in`=8'hAB → `data_out`=8'hAB after the accept edge; `done` pulses for one cycle; `busy` stays 0.
- Shift right: from 8'hAB, mode 001, amount 3, `sr_ser`=1 → steps give 8'hD5, 8'hEA, 8'hF5. `ser_out` ends at 0. `busy` is high 3 cycles, then `done` for 1 cycle.
- Rotate and arithmetic shift:
  - From 8'hAB, rotate left by 8 → 8'hAB.
  - Then rotate left by 1 → 8'h57, `ser_out`=1.
  - Load 8'h90, arithmetic shift right by 2 → 8'hE4.
- Handshake edges:
  - `start` pulsed during SHIFT is ignored; the running result is unaffected.
  - amount=0 with shift left → unchanged data, `done` next cycle.
  - `start` during DONE → the new command is accepted with no gap.
- Streaming: shift left, amount 8, `sl_ser` driving 1,0,1,1,0,0,1,0 on successive steps → `data_out`=8'hB2.
